// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ARM pipeline execute stage: operand select, ALU, condition check, EX/MEM register
//
// Purpose:
//   Execute (E) stage of the 5-stage ARM datapath. It selects forwarded or
//   register operands, runs the 32-bit ALU and produces NZCV. It also
//   evaluates the condition field against the incoming flags. The stage then
//   loads the condition-gated controls and data into the EX/MEM register.
//
// Ports:
//   Clk, reset                  rising-edge clock, async active-low reset
//   dataRegAIn/BIn/CIn          Rn, Rm and store-data register values
//   extIn                       extended immediate
//   ResultW                     writeback result (forwarding source)
//   ADataMem                    reserved, ignored in this revision
//   WA3E                        destination register
//   ALUControlE                 ALU operation select
//   flagsE                      current flags {N,Z,C,V}
//   CondE                       ARM condition field
//   RegWriteE, BranchE, PCSrcE,
//   MemToRegE, MemWriteDin      decoded controls
//   ALUSrcE, PlusOneIn          SrcB select (immediate / constant one)
//   FlagWriteEin                instruction updates flags
//   ForwardAE, ForwardBE        take ResultW instead of register value
//   ALUResultE, flagsEout,
//   BranchTakenE                combinational E-stage results
//   WA3Mout, AToMemout,
//   WDToMemout, PCSrcMout,
//   RegWriteMout, MemToRegMout,
//   MemWriteEout                registered EX/MEM outputs

module execute_stage (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] dataRegAIn,
    input  logic [31:0] dataRegBIn,
    input  logic [31:0] dataRegCIn,
    input  logic [31:0] extIn,
    input  logic [31:0] ResultW,
    input  logic [31:0] ADataMem,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  ALUControlE,
    input  logic [3:0]  flagsE,
    input  logic [3:0]  CondE,
    input  logic        RegWriteE,
    input  logic        BranchE,
    input  logic        PCSrcE,
    input  logic        MemToRegE,
    input  logic        MemWriteDin,
    input  logic        ALUSrcE,
    input  logic        PlusOneIn,
    input  logic        FlagWriteEin,
    input  logic        ForwardAE,
    input  logic        ForwardBE,
    output logic [31:0] ALUResultE,
    output logic [3:0]  flagsEout,
    output logic        BranchTakenE,
    output logic [3:0]  WA3Mout,
    output logic [31:0] AToMemout,
    output logic [31:0] WDToMemout,
    output logic        PCSrcMout,
    output logic        RegWriteMout,
    output logic        MemToRegMout,
    output logic        MemWriteEout
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;
    localparam logic [3:0] ALU_MVN = 4'b0110;
    localparam logic [3:0] ALU_BIC = 4'b0111;
    localparam logic [3:0] ALU_RSB = 4'b1000;
    localparam logic [3:0] ALU_CMP = 4'b1001;

    // Memory-address path from the memory stage is not used yet.
    logic unused_adatamem;
    assign unused_adatamem = ^ADataMem;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [31:0] src_a;
    logic [31:0] b_fwd;
    logic [31:0] src_b;

    assign src_a = ForwardAE ? ResultW : dataRegAIn;
    assign b_fwd = ForwardBE ? ResultW : dataRegBIn;
    // The constant-one path wins over the immediate path.
    assign src_b = PlusOneIn ? 32'd1 : (ALUSrcE ? extIn : b_fwd);

    // ------------------------------------------------------------------
    // Shared adder: every arithmetic op is x + y + cin, with subtraction
    // done as x + ~y + 1 so the carry-out reads as "no borrow".
    // ------------------------------------------------------------------
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] add_sum;
    logic        is_arith;
    logic        is_valid;

    always_comb begin
        add_x    = src_a;
        add_y    = src_b;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        case (ALUControlE)
            ALU_ADD: begin
                is_arith = 1'b1;
            end
            ALU_SUB, ALU_CMP: begin
                add_y    = ~src_b;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            ALU_RSB: begin
                add_x    = src_b;
                add_y    = ~src_a;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            default: begin
                is_arith = 1'b0;
            end
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    // ------------------------------------------------------------------
    // Result mux
    // ------------------------------------------------------------------
    always_comb begin
        ALUResultE = 32'd0;
        is_valid   = 1'b1;
        case (ALUControlE)
            ALU_ADD, ALU_SUB, ALU_RSB, ALU_CMP: ALUResultE = add_sum[31:0];
            ALU_AND: ALUResultE = src_a & src_b;
            ALU_ORR: ALUResultE = src_a | src_b;
            ALU_EOR: ALUResultE = src_a ^ src_b;
            ALU_MOV: ALUResultE = src_b;
            ALU_MVN: ALUResultE = ~src_b;
            ALU_BIC: ALUResultE = src_a & ~src_b;
            default: begin
                ALUResultE = 32'd0;
                is_valid   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU flags. Overflow: both adder inputs share a sign and the sum's
    // sign differs. Logic/move ops keep the incoming C and V; undefined
    // codes leave all four flags untouched.
    // ------------------------------------------------------------------
    logic [3:0] alu_flags;
    logic       alu_n;
    logic       alu_z;
    logic       alu_c;
    logic       alu_v;

    assign alu_n = ALUResultE[31];
    assign alu_z = (ALUResultE == 32'd0);
    assign alu_c = is_arith ? add_sum[32] : flagsE[1];
    assign alu_v = is_arith ? ((add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]))
                            : flagsE[0];
    assign alu_flags = is_valid ? {alu_n, alu_z, alu_c, alu_v} : flagsE;

    // ------------------------------------------------------------------
    // Condition evaluation against the current flags
    // ------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_ex;

    assign {flag_n, flag_z, flag_c, flag_v} = flagsE;

    always_comb begin
        cond_ex = 1'b1;
        case (CondE)
            4'h0: cond_ex = flag_z;
            4'h1: cond_ex = ~flag_z;
            4'h2: cond_ex = flag_c;
            4'h3: cond_ex = ~flag_c;
            4'h4: cond_ex = flag_n;
            4'h5: cond_ex = ~flag_n;
            4'h6: cond_ex = flag_v;
            4'h7: cond_ex = ~flag_v;
            4'h8: cond_ex = flag_c & ~flag_z;
            4'h9: cond_ex = ~flag_c | flag_z;
            4'hA: cond_ex = (flag_n == flag_v);
            4'hB: cond_ex = (flag_n != flag_v);
            4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ex = flag_z | (flag_n != flag_v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign flagsEout    = (FlagWriteEin & cond_ex) ? alu_flags : flagsE;
    assign BranchTakenE = BranchE & cond_ex;

    // ------------------------------------------------------------------
    // EX/MEM register. Loads every cycle. Side-effecting controls are
    // squashed here when the condition fails.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            WA3Mout      <= 4'd0;
            AToMemout    <= 32'd0;
            WDToMemout   <= 32'd0;
            PCSrcMout    <= 1'b0;
            RegWriteMout <= 1'b0;
            MemToRegMout <= 1'b0;
            MemWriteEout <= 1'b0;
        end else begin
            WA3Mout      <= WA3E;
            AToMemout    <= ALUResultE;
            WDToMemout   <= dataRegCIn;
            PCSrcMout    <= PCSrcE & cond_ex;
            RegWriteMout <= RegWriteE & cond_ex;
            MemToRegMout <= MemToRegE;
            MemWriteEout <= MemWriteDin & cond_ex;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage

module tb_execute_stage;

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] dataRegAIn, dataRegBIn, dataRegCIn, extIn, ResultW, ADataMem;
    logic [3:0]  WA3E, ALUControlE, flagsE, CondE;
    logic        RegWriteE, BranchE, PCSrcE, MemToRegE, MemWriteDin;
    logic        ALUSrcE, PlusOneIn, FlagWriteEin, ForwardAE, ForwardBE;
    logic [31:0] ALUResultE;
    logic [3:0]  flagsEout;
    logic        BranchTakenE;
    logic [3:0]  WA3Mout;
    logic [31:0] AToMemout, WDToMemout;
    logic        PCSrcMout, RegWriteMout, MemToRegMout, MemWriteEout;

    int tests_run = 0;
    int tests_failed = 0;

    execute_stage dut (
        .Clk(Clk), .reset(reset),
        .dataRegAIn(dataRegAIn), .dataRegBIn(dataRegBIn), .dataRegCIn(dataRegCIn),
        .extIn(extIn), .ResultW(ResultW), .ADataMem(ADataMem),
        .WA3E(WA3E), .ALUControlE(ALUControlE), .flagsE(flagsE), .CondE(CondE),
        .RegWriteE(RegWriteE), .BranchE(BranchE), .PCSrcE(PCSrcE),
        .MemToRegE(MemToRegE), .MemWriteDin(MemWriteDin),
        .ALUSrcE(ALUSrcE), .PlusOneIn(PlusOneIn), .FlagWriteEin(FlagWriteEin),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultE(ALUResultE), .flagsEout(flagsEout), .BranchTakenE(BranchTakenE),
        .WA3Mout(WA3Mout), .AToMemout(AToMemout), .WDToMemout(WDToMemout),
        .PCSrcMout(PCSrcMout), .RegWriteMout(RegWriteMout),
        .MemToRegMout(MemToRegMout), .MemWriteEout(MemWriteEout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        dataRegAIn = 32'd0; dataRegBIn = 32'd0; dataRegCIn = 32'd0;
        extIn = 32'd0; ResultW = 32'd0; ADataMem = 32'd0;
        WA3E = 4'd0; ALUControlE = 4'd0; flagsE = 4'd0; CondE = 4'hE;
        RegWriteE = 1'b0; BranchE = 1'b0; PCSrcE = 1'b0;
        MemToRegE = 1'b0; MemWriteDin = 1'b0;
        ALUSrcE = 1'b0; PlusOneIn = 1'b0; FlagWriteEin = 1'b0;
        ForwardAE = 1'b0; ForwardBE = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".wa3"},  {28'd0, WA3Mout}, 32'd0);
        check({tag, ".ato"},  AToMemout, 32'd0);
        check({tag, ".wd"},   WDToMemout, 32'd0);
        check({tag, ".ctl"},  {28'd0, PCSrcMout, RegWriteMout, MemToRegMout, MemWriteEout}, 32'd0);
    endtask

    logic [15:0] cond_exp_a;
    logic [15:0] cond_exp_b;

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1;
        check_regs_zero("reset_init");
        tick();
        tick();
        @(negedge Clk);
        reset = 1'b1;

        // ALU basics
        dataRegAIn = 32'd5; dataRegBIn = 32'd2; ALUControlE = 4'b0001;
        #1 check("sub_5_2", ALUResultE, 32'd3);
        tick();
        check("sub_reg", AToMemout, 32'd3);
        ALUControlE = 4'b0000; #1 check("add_5_2", ALUResultE, 32'd7);
        ALUControlE = 4'b0010; #1 check("and_5_2", ALUResultE, 32'd0);
        ALUControlE = 4'b0011; #1 check("orr_5_2", ALUResultE, 32'd7);
        ALUControlE = 4'b0100; #1 check("eor_5_2", ALUResultE, 32'd7);
        ALUControlE = 4'b0101; #1 check("mov_2", ALUResultE, 32'd2);
        ALUControlE = 4'b0110; #1 check("mvn_2", ALUResultE, 32'hFFFFFFFD);
        ALUControlE = 4'b0111; #1 check("bic_5_2", ALUResultE, 32'd5);
        ALUControlE = 4'b1000; FlagWriteEin = 1'b1;
        #1 check("rsb_2_5", ALUResultE, 32'hFFFFFFFD);
        check("rsb_flags", {28'd0, flagsEout}, 32'h8);
        flagsE = 4'b0110; ALUControlE = 4'b1010;
        #1 check("undef_res", ALUResultE, 32'd0);
        check("undef_flags", {28'd0, flagsEout}, 32'h6);
        flagsE = 4'b0000; FlagWriteEin = 1'b0;

        // Forwarding and SrcB selection
        ALUControlE = 4'b0001; ForwardAE = 1'b1; ResultW = 32'd100;
        #1 check("fwd_a_sub", ALUResultE, 32'd98);
        ForwardAE = 1'b0; ForwardBE = 1'b1; ResultW = 32'd10; FlagWriteEin = 1'b1;
        #1 check("fwd_b_sub", ALUResultE, 32'hFFFFFFFB);
        check("fwd_b_flags", {28'd0, flagsEout}, 32'h8);
        ForwardBE = 1'b0; FlagWriteEin = 1'b0;
        ALUControlE = 4'b0000; ALUSrcE = 1'b1; extIn = 32'd7;
        #1 check("imm_add", ALUResultE, 32'd12);
        PlusOneIn = 1'b1;
        #1 check("plus_one", ALUResultE, 32'd6);
        PlusOneIn = 1'b0; ALUSrcE = 1'b0;

        // Flags
        dataRegBIn = 32'd5; ALUControlE = 4'b1001; FlagWriteEin = 1'b1; CondE = 4'hE;
        #1 check("cmp_5_5_res", ALUResultE, 32'd0);
        check("cmp_5_5_flags", {28'd0, flagsEout}, 32'h6);
        dataRegAIn = 32'd0; dataRegBIn = 32'd1; ALUControlE = 4'b0001;
        #1 check("sub_0_1_flags", {28'd0, flagsEout}, 32'h8);
        dataRegAIn = 32'h7FFFFFFF; ALUControlE = 4'b0000;
        #1 check("ovf_res", ALUResultE, 32'h80000000);
        check("ovf_flags", {28'd0, flagsEout}, 32'h9);
        flagsE = 4'b0011; FlagWriteEin = 1'b0;
        #1 check("no_flagwrite", {28'd0, flagsEout}, 32'h3);
        dataRegAIn = 32'h80000000; dataRegBIn = 32'd0; ALUControlE = 4'b0011; FlagWriteEin = 1'b1;
        #1 check("orr_cv_pass", {28'd0, flagsEout}, 32'hB);
        FlagWriteEin = 1'b0;

        // Condition table: bit i is expected CondEx for CondE=i
        cond_exp_a = 16'b1110_1001_1001_0110;   // flags N=1 Z=0 C=1 V=0
        cond_exp_b = 16'b1110_1010_0110_1001;   // flags N=0 Z=1 C=0 V=1
        BranchE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            CondE = 4'(i);
            flagsE = 4'b1010;
            #1 check($sformatf("cond_a_%0d", i), {31'd0, BranchTakenE}, {31'd0, cond_exp_a[i]});
            flagsE = 4'b0101;
            #1 check($sformatf("cond_b_%0d", i), {31'd0, BranchTakenE}, {31'd0, cond_exp_b[i]});
        end

        // Condition gating into EX/MEM
        dataRegAIn = 32'd5; dataRegBIn = 32'd2; ALUControlE = 4'b0000;
        flagsE = 4'b0100; CondE = 4'h0;
        RegWriteE = 1'b1; MemWriteDin = 1'b1; PCSrcE = 1'b1; BranchE = 1'b1;
        #1 check("eq_branch", {31'd0, BranchTakenE}, 32'd1);
        tick();
        check("eq_ctl", {29'd0, RegWriteMout, MemWriteEout, PCSrcMout}, 32'h7);
        CondE = 4'h1; FlagWriteEin = 1'b1;
        #1 check("ne_branch", {31'd0, BranchTakenE}, 32'd0);
        check("ne_flags_hold", {28'd0, flagsEout}, 32'h4);
        tick();
        check("ne_ctl", {29'd0, RegWriteMout, MemWriteEout, PCSrcMout}, 32'h0);
        FlagWriteEin = 1'b0; CondE = 4'hE;

        // Pipeline register transfer
        WA3E = 4'hA; MemToRegE = 1'b1; dataRegCIn = 32'hDEADBEEF;
        tick();
        check("xfer_wa3", {28'd0, WA3Mout}, 32'hA);
        check("xfer_m2r", {31'd0, MemToRegMout}, 32'd1);
        check("xfer_wd", WDToMemout, 32'hDEADBEEF);
        check("xfer_ato", AToMemout, 32'd7);

        // Reset mid-operation
        @(negedge Clk);
        reset = 1'b0;
        #1 check_regs_zero("rst_async");
        check("rst_comb_live", ALUResultE, 32'd7);
        tick();
        tick();
        check_regs_zero("rst_hold");
        @(negedge Clk);
        reset = 1'b1;
        #1 check_regs_zero("rst_release");
        tick();
        check("rel_wa3", {28'd0, WA3Mout}, 32'hA);
        check("rel_wd", WDToMemout, 32'hDEADBEEF);
        check("rel_ctl", {28'd0, PCSrcMout, RegWriteMout, MemToRegMout, MemWriteEout}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
